// File: rtl/vga_scan.sv
// ---------------------------------------------------------------------------
// vga_scan
// Raster scan generator and VGA output stage for the snake game.
//
// A clock divider produces a one-clk pix_tick every CLK_DIV system clocks.
// On each tick the horizontal and vertical counters advance through the
// H_TOTAL x V_TOTAL raster. The counters are exported as pix_x/pix_y so the
// game model can return the colour of that pixel on color_in. On the next
// tick the colour is captured into the output register, together with
// hsync/vsync decoded from the same pre-increment counters. All VGA outputs
// therefore lag the coordinates by exactly one pixel period.
//
// Ports
//   clk          system clock (single clock domain)
//   reset        asynchronous reset, active low
//   color_in     {R[3:0],G[3:0],B[3:0]} for the current pix_x/pix_y
//   pix_x/pix_y  current raster position, zero-extended, never negative
//   pix_tick     high on the last clk of every pixel period
//   frame_start  one-clk pulse after the raster wraps to (0,0)
//   hsync/vsync  active-low sync, aligned with the RGB outputs
//   vga_r/g/b    pixel colour, forced to 0 outside the active area
// ---------------------------------------------------------------------------
module vga_scan #(
   parameter int CLK_DIV   = 4,
   parameter int COLOR_LAT = 1,
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [11:0]        color_in,
   output logic signed [15:0] pix_x,
   output logic signed [15:0] pix_y,
   output logic               pix_tick,
   output logic               frame_start,
   output logic               hsync,
   output logic               vsync,
   output logic [3:0]         vga_r,
   output logic [3:0]         vga_g,
   output logic [3:0]         vga_b
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam int DW = $clog2(CLK_DIV);
   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);

   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

   // The colour is sampled CLK_DIV-1 clks after the coordinates move, so the
   // model's response latency has to fit inside that window.
   if (CLK_DIV < 2 || COLOR_LAT >= CLK_DIV) begin : g_param_err
      $error("vga_scan: need CLK_DIV >= 2 and COLOR_LAT < CLK_DIV");
   end

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [DW-1:0] div_cnt_q, div_cnt_d;
   logic [HW-1:0] h_cnt_q,   h_cnt_d;
   logic [VW-1:0] v_cnt_q,   v_cnt_d;

   logic          hsync_q,   hsync_d;
   logic          vsync_q,   vsync_d;
   logic [11:0]   rgb_q,     rgb_d;
   logic          fstart_q,  fstart_d;

   // ------------------------------------------------------------------
   // Raster decode of the pixel currently being shown
   // ------------------------------------------------------------------
   logic tick;
   logic h_wrap;
   logic v_wrap;
   logic active;
   logic in_hs;
   logic in_vs;

   assign tick   = (div_cnt_q == DIV_LAST);
   assign h_wrap = (h_cnt_q == H_LAST);
   assign v_wrap = (v_cnt_q == V_LAST);
   assign active = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
   assign in_hs  = (h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END);
   assign in_vs  = (v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END);

   // ------------------------------------------------------------------
   // Divider and raster counters
   // ------------------------------------------------------------------
   always_comb begin
      div_cnt_d = div_cnt_q + 1'b1;
      h_cnt_d   = h_cnt_q;
      v_cnt_d   = v_cnt_q;

      if (tick) begin
         div_cnt_d = '0;
         if (h_wrap) begin
            h_cnt_d = '0;
            v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
         end else begin
            h_cnt_d = h_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_cnt_q <= '0;
         h_cnt_q   <= '0;
         v_cnt_q   <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
         h_cnt_q   <= h_cnt_d;
         v_cnt_q   <= v_cnt_d;
      end
   end

   // ------------------------------------------------------------------
   // Output register stage
   // Loaded from the pre-increment counters, i.e. the pixel being left,
   // which is the pixel color_in currently describes.
   // ------------------------------------------------------------------
   always_comb begin
      hsync_d  = hsync_q;
      vsync_d  = vsync_q;
      rgb_d    = rgb_q;
      // Only the wrap out of the last pixel of the frame marks a frame
      // start; the restart at (0,0) after reset does not.
      fstart_d = tick && h_wrap && v_wrap;

      if (tick) begin
         hsync_d = !in_hs;
         vsync_d = !in_vs;
         rgb_d   = active ? color_in : 12'h000;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hsync_q  <= 1'b1;
         vsync_q  <= 1'b1;
         rgb_q    <= '0;
         fstart_q <= 1'b0;
      end else begin
         hsync_q  <= hsync_d;
         vsync_q  <= vsync_d;
         rgb_q    <= rgb_d;
         fstart_q <= fstart_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign pix_x       = signed'(16'(h_cnt_q));
   assign pix_y       = signed'(16'(v_cnt_q));
   assign pix_tick    = tick;
   assign frame_start = fstart_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign vga_r       = rgb_q[11:8];
   assign vga_g       = rgb_q[7:4];
   assign vga_b       = rgb_q[3:0];

endmodule
